// File: rtl/alu_pkg.sv
// Shared definitions for the sequenced ALU: op codes, FSM states, default width.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package alu_pkg;

    // Default datapath width, matched to the downstream accumulator
    localparam int DEFAULT_WIDTH = 8;

    // Operation codes, sampled together with start
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_NOT   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    // True for the op that uses the multi-cycle multiplier path
    function automatic logic is_mul_op(input logic [2:0] op_code);
        return (op_code == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle, full 2*WIDTH product.
// Latency: operands loaded on the start edge, done pulses WIDTH edges later.
// Backpressure: none; a start while active restarts the multiply, caller gates start.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q,  prod_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               active_q, active_d;
    logic               done_q,  done_d;

    // Load operands on start, then add the shifted multiplicand for each set multiplier bit
    always_comb begin
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        done_d   = 1'b0;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a_in};
            mplier_d = b_in;
            prod_d   = '0;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    // State registers; synchronous reset aborts any multiply in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: rtl/alu_seq.sv
// Sequenced ALU feeding the accumulator: one op per start, result + load_acc strobe (MUL path under ALU_MUL_EN).
// Latency: done 2 cycles after the accept edge (counted inclusively) for single-cycle ops, WIDTH+2 for MUL.
// Backpressure: start accepted only in IDLE; requests while busy are dropped, not queued.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             load_acc,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    state_t           state_q, state_d;
    logic [2:0]       op_q,    op_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q,  zero_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_cy;
    logic [WIDTH:0]   add_ext;

`ifdef ALU_MUL_EN
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    // The multiplier captures its own copy of the operands on the accept edge
    assign mul_start = (state_q == IDLE) && start && is_mul_op(op);

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a_in    (acc_in),
        .b_in    (b_in),
        .done    (mul_done),
        .product (mul_prod)
    );
`endif

    // Single-cycle datapath working only from the latched operands
    always_comb begin
        add_ext = {1'b0, a_q} + {1'b0, b_q};
        alu_res = '0;
        alu_cy  = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_cy  = add_ext[WIDTH];
            end
            OP_SUB: begin
                alu_res = a_q - b_q;
                alu_cy  = (a_q >= b_q);
            end
            OP_AND:   alu_res = a_q & b_q;
            OP_OR:    alu_res = a_q | b_q;
            OP_XOR:   alu_res = a_q ^ b_q;
            OP_NOT:   alu_res = ~a_q;
            // Without the multiplier, MUL collapses to a zero result here
            OP_MUL:   alu_res = '0;
            OP_PASSB: alu_res = b_q;
            default:  alu_res = '0;
        endcase
    end

    // Next-state and registered-output logic for the IDLE/EXEC/MUL/DONE sequencer
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    op_d   = op;
                    a_d    = acc_in;
                    b_d    = b_in;
                    busy_d = 1'b1;
`ifdef ALU_MUL_EN
                    state_d = is_mul_op(op) ? MUL : EXEC;
`else
                    state_d = EXEC;
`endif
                end
            end
            EXEC: begin
                state_d  = DONE;
                done_d   = 1'b1;
                result_d = alu_res;
                carry_d  = alu_cy;
                zero_d   = (alu_res == '0);
            end
            MUL: begin
`ifdef ALU_MUL_EN
                if (mul_done) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = mul_prod[WIDTH-1:0];
                    carry_d  = |mul_prod[2*WIDTH-1:WIDTH];
                    zero_d   = (mul_prod[WIDTH-1:0] == '0);
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state and outputs; synchronous active-low reset aborts without a done
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign load_acc = done_q;
    assign result   = result_q;
    assign carry    = carry_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (expectations follow ALU_MUL_EN).
// Latency: counted inclusively from the accept edge to the edge that raises done.
// Backpressure: exercises dropped start requests while busy.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;

`ifdef ALU_MUL_EN
    localparam int         MUL_LAT = 10;
    localparam logic [7:0] MUL1_RES = 8'hFF;
    localparam logic       MUL1_CY  = 1'b0;
    localparam logic       MUL1_Z   = 1'b0;
    localparam logic [7:0] MUL2_RES = 8'h00;
    localparam logic       MUL2_CY  = 1'b1;
    localparam logic       MUL2_Z   = 1'b1;
`else
    localparam int         MUL_LAT = 2;
    localparam logic [7:0] MUL1_RES = 8'h00;
    localparam logic       MUL1_CY  = 1'b0;
    localparam logic       MUL1_Z   = 1'b1;
    localparam logic [7:0] MUL2_RES = 8'h00;
    localparam logic       MUL2_CY  = 1'b0;
    localparam logic       MUL2_Z   = 1'b1;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] acc_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic         load_acc;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .acc_in   (acc_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .load_acc (load_acc),
        .result   (result),
        .carry    (carry),
        .zero     (zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, scramble the operand inputs after acceptance, then check latency and outputs
    task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] a,
                          input logic [7:0] b, input int exp_lat, input logic [7:0] er,
                          input logic ec, input logic ez);
        int lat;
        start  = 1'b1;
        op     = o;
        acc_in = a;
        b_in   = b;
        tick();
        start  = 1'b0;
        acc_in = ~a;
        b_in   = ~b;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"},   32'(lat),      32'(exp_lat));
        chk({tag, "_load"},  32'(load_acc), 32'd1);
        chk({tag, "_res"},   32'(result),   32'(er));
        chk({tag, "_carry"}, 32'(carry),    32'(ec));
        chk({tag, "_zero"},  32'(zero),     32'(ez));
        tick();
        chk({tag, "_pulse"}, 32'(done),     32'd0);
        chk({tag, "_idle"},  32'(busy),     32'd0);
    endtask

    initial begin
        int ndone;

        // Reset held with start asserted
        reset  = 1'b0;
        start  = 1'b1;
        op     = OP_ADD;
        acc_in = 8'hFF;
        b_in   = 8'h01;
        tick();
        tick();
        chk("rst_busy",   32'(busy),     32'd0);
        chk("rst_done",   32'(done),     32'd0);
        chk("rst_load",   32'(load_acc), 32'd0);
        chk("rst_result", 32'(result),   32'd0);
        chk("rst_carry",  32'(carry),    32'd0);
        chk("rst_zero",   32'(zero),     32'd0);
        start = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rel_nodone", 32'(done), 32'd0);
        end

        // Single-cycle ops
        run_op("add_wrap", OP_ADD,   8'hFF, 8'h01, 2, 8'h00, 1'b1, 1'b1);
        run_op("sub_brw",  OP_SUB,   8'h05, 8'h07, 2, 8'hFE, 1'b0, 1'b0);
        run_op("sub_eq",   OP_SUB,   8'hAA, 8'hAA, 2, 8'h00, 1'b1, 1'b1);
        run_op("add",      OP_ADD,   8'h12, 8'h34, 2, 8'h46, 1'b0, 1'b0);
        run_op("and",      OP_AND,   8'hF0, 8'h3C, 2, 8'h30, 1'b0, 1'b0);
        run_op("or",       OP_OR,    8'hF0, 8'h0C, 2, 8'hFC, 1'b0, 1'b0);
        run_op("xor",      OP_XOR,   8'h5A, 8'h5A, 2, 8'h00, 1'b0, 1'b1);
        run_op("not",      OP_NOT,   8'h0F, 8'h55, 2, 8'hF0, 1'b0, 1'b0);
        run_op("passb",    OP_PASSB, 8'h00, 8'h77, 2, 8'h77, 1'b0, 1'b0);

        // Multiply
        run_op("mul_ff",   OP_MUL,   8'h0F, 8'h11, MUL_LAT, MUL1_RES, MUL1_CY, MUL1_Z);
        run_op("mul_ovf",  OP_MUL,   8'h10, 8'h10, MUL_LAT, MUL2_RES, MUL2_CY, MUL2_Z);

        // A second request while busy must be dropped
        start  = 1'b1;
        op     = OP_MUL;
        acc_in = 8'h0F;
        b_in   = 8'h11;
        tick();
        start  = 1'b1;
        op     = OP_ADD;
        acc_in = 8'h01;
        b_in   = 8'h01;
        tick();
        start  = 1'b0;
        ndone  = (done === 1'b1) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("hold_ndone",  32'(ndone),  32'd1);
        chk("hold_result", 32'(result), 32'(MUL1_RES));
        chk("hold_carry",  32'(carry),  32'(MUL1_CY));
        chk("hold_zero",   32'(zero),   32'(MUL1_Z));

        // Reset four cycles into a multiply
        start  = 1'b1;
        op     = OP_MUL;
        acc_in = 8'h0F;
        b_in   = 8'h11;
        tick();
        start  = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b0;
        tick();
        chk("mrst_busy",   32'(busy),   32'd0);
        chk("mrst_done",   32'(done),   32'd0);
        chk("mrst_result", 32'(result), 32'd0);
        chk("mrst_zero",   32'(zero),   32'd0);
        reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("mrst_nodone", 32'(ndone), 32'd0);
        run_op("post_rst_add", OP_ADD, 8'h12, 8'h34, 2, 8'h46, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Sequenced ALU stage directly upstream of the accumulator register. It takes the accumulator's current value (acc_out) and a B operand, and runs one operation per start request. It returns result plus a one-cycle load_acc strobe that drives the accumulator's data_in/load_acc pins. Single-cycle logic ops and a multi-cycle shift-add multiply share one handshake and FSM.

Parameters:
WIDTH, 8, datapath width; must match the accumulator width.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
start  input  1  request; accepted only in IDLE.
op  input  3  operation code, sampled with start.
acc_in  input  WIDTH  A operand, from accumulator acc_out.
b_in  input  WIDTH  B operand.
busy  output  1  high from the cycle after acceptance through DONE.
done  output  1  one-cycle pulse; result and flags valid.
load_acc  output  1  identical to done; drives the accumulator's load_acc.
result  output  WIDTH  operation result; held until the next done.
carry  output  1  carry/borrow/overflow flag; held until the next done.
zero  output  1  result==0 flag; held until the next done.

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE; busy=0, done=0, load_acc=0, result=0, carry=0, zero=0. Any in-flight op is aborted with no done.
- States: IDLE, EXEC, MUL, DONE.
- IDLE: start==1 -> latch op, acc_in, b_in into internal regs; go to EXEC if op!=110, else MUL. start==0 -> stay.
- Operands are latched at acceptance; later changes on acc_in/b_in have no effect.
- EXEC (1 cycle): compute from latched operands; go to DONE.
- MUL: unsigned shift-add, one multiplier bit per cycle, exactly WIDTH cycles, then DONE.
- DONE (1 cycle): done=load_acc=1; result/carry/zero update on entry; return to IDLE.
- start is ignored outside IDLE. It is not queued and does not need to be held.
- Earliest re-accept is the cycle after DONE.
- Latency, counted as start-accept edge to done high: single-cycle ops = 2 cycles; MUL = WIDTH+2 cycles (10 for WIDTH=8).
- Ops (A=latched acc, B=latched b):
  - 000 ADD: A+B mod 2^WIDTH; carry = carry-out.
  - 001 SUB: A-B mod 2^WIDTH; carry = 1 if A>=B (no borrow).
  - 010 AND, 011 OR, 100 XOR: bitwise; carry=0.
  - 101 NOT: ~A; carry=0.
  - 110 MUL: low WIDTH bits of A*B; carry = 1 if the upper WIDTH bits are nonzero.
  - 111 PASSB: B (load B into accumulator); carry=0.
- zero = (result==0), evaluated on the new result.
- Flags and result change only at DONE.

Optional Feature:
ALU_MUL_EN
- Defined: op 110 runs the multi-cycle MUL path as specified above.
- Undefined: MUL state and multiplier logic are not built. Op 110 takes the EXEC path (2-cycle latency) and returns result=0, carry=0, zero=1.

Decomposition:
- Package alu_pkg holds:
  - op code constants OP_ADD..OP_PASSB (3-bit);
  - state enum typedef (IDLE, EXEC, MUL, DONE);
  - default WIDTH constant.
- One sub-module, alu_mul_seq: shift-add multiplier with start/done and a 2*WIDTH product, instantiated only under ALU_MUL_EN.
- The rest stays in alu_seq.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1 -> busy=0, done=0, result=0x00, carry=0, zero=0. Release -> IDLE; no spurious done.
- ADD wrap: A=0xFF, B=0x01, op=000 -> 2 cycles later done=load_acc=1 for exactly one cycle, result=0x00, carry=1, zero=1.
- SUB borrow: A=0x05, B=0x07, op=001 -> result=0xFE, carry=0, zero=0. Then A=0xAA, B=0xAA -> result=0x00, carry=1, zero=1.
- MUL:
  - A=0x0F, B=0x11, op=110 -> done exactly 10 cycles after accept; result=0xFF, carry=0.
  - A=0x10, B=0x10 -> result=0x00, carry=1, zero=1.
  - Without ALU_MUL_EN -> 2-cycle latency; result=0x00, carry=0, zero=1.
- Busy/operand hold: during MUL, pulse start with op=000 and change acc_in/b_in -> the second request is ignored, the MUL result is unaffected, and only one done occurs.
- Reset mid-op: assert reset 4 cycles into MUL -> next cycle busy=0, result=0, no done. A new ADD 0x12+0x34 then yields 0x46.
